// File: rtl/key_pkg.sv
// Shared mode encodings and default timing constants for the push-button
// controller (key_ctrl and key_debounce).
package key_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SEC  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_HOUR = 2'd3
  } mode_t;

  localparam int unsigned DEF_DEB_CNT = 1000000;
  localparam int unsigned DEF_REP_DLY = 25000000;
  localparam int unsigned DEF_REP_PER = 5000000;

  localparam int NUM_KEYS = 3;
  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_CLR  = 2;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, stable-time debounce counter and a
// registered one-cycle press pulse (released->pressed only).
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned P_DEB_CNT = DEF_DEB_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic press
);

  localparam int CW = (P_DEB_CNT > 1) ? $clog2(P_DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(P_DEB_CNT - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;
  logic          pressed;

  // Raw input is active-low; sync resets to the released level.
  assign pressed = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], sw};
      level_d <= level;
      press   <= level & ~level_d;
      if (pressed != level) begin
        if (cnt == CNT_MAX) begin
          level <= pressed;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/key_ctrl.sv
// Time-set button controller: three debounced keys drive a 4-state mode FSM
// and inc/clear pulses. Define KEY_AUTOREPEAT_EN to auto-repeat a held increment.
module key_ctrl
  import key_pkg::*;
#(
  parameter int unsigned P_DEB_CNT = DEF_DEB_CNT,
  parameter int unsigned P_REP_DLY = DEF_REP_DLY,
  parameter int unsigned P_REP_PER = DEF_REP_PER
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_sw,
  output logic [1:0] o_mode,
  output logic       o_inc,
  output logic       o_clr,
  output logic [2:0] o_sw_state
);

  logic [NUM_KEYS-1:0] press;
  mode_t               mode;

  key_debounce #(.P_DEB_CNT(P_DEB_CNT)) u_deb [NUM_KEYS-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (i_sw),
    .level (o_sw_state),
    .press (press)
  );

  assign o_mode = mode;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (P_REP_DLY > P_REP_PER) ? P_REP_DLY : P_REP_PER;
  localparam int RW = $clog2(REP_MAX + 1);

  logic          rep_act;
  logic          rep_first;
  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  assign rep_fire = rep_act && o_sw_state[KEY_INC] &&
                    (rep_cnt == (rep_first ? RW'(P_REP_DLY - 1) : RW'(P_REP_PER - 1)));
`endif

  // Priority clear > mode > increment; lower presses in the same cycle are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= MODE_RUN;
      o_inc <= 1'b0;
      o_clr <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
`endif
    end else begin
      o_inc <= 1'b0;
      o_clr <= 1'b0;
      if (press[KEY_CLR]) begin
        o_clr <= 1'b1;
        mode  <= MODE_RUN;
      end else if (press[KEY_MODE]) begin
        mode <= next_mode(mode);
      end else if (press[KEY_INC] && mode != MODE_RUN) begin
        o_inc <= 1'b1;
      end
`ifdef KEY_AUTOREPEAT_EN
      // Any mode change or release ends the repeat run.
      if (press[KEY_CLR] || press[KEY_MODE] || !o_sw_state[KEY_INC]) begin
        rep_act <= 1'b0;
      end else if (press[KEY_INC] && mode != MODE_RUN) begin
        rep_act   <= 1'b1;
        rep_first <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_act) begin
        if (rep_fire) begin
          o_inc     <= 1'b1;
          rep_first <= 1'b0;
          rep_cnt   <= '0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: directed table, reset/latency sequences and random
// button activity against a cycle-level behavioural model.
module tb_key_ctrl;
  import key_pkg::*;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_INCS = 5;
`else
  localparam int REP_INCS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] i_sw = 3'b111;
  logic [1:0] o_mode;
  logic       o_inc, o_clr;
  logic [2:0] o_sw_state;

  key_ctrl #(.P_DEB_CNT(DEB), .P_REP_DLY(DLY), .P_REP_PER(PER)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(i_sw), .o_mode(o_mode),
    .o_inc(o_inc), .o_clr(o_clr), .o_sw_state(o_sw_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model, pressed-sense (1 = pressed)
  logic [2:0] m_sy1, m_sy2, m_stab, m_rose, m_ev;
  int m_streak[3];
  int m_mode, m_due, cyc;
  bit m_inc, m_clr, m_rep;

  task automatic m_reset();
    m_sy1 = '0; m_sy2 = '0; m_stab = '0; m_rose = '0; m_ev = '0;
    for (int b = 0; b < 3; b++) m_streak[b] = 0;
    m_mode = 0; m_inc = 0; m_clr = 0; m_rep = 0; m_due = 0;
  endtask

  task automatic m_step(input logic [2:0] raw, input logic rst);
    logic [2:0] ev, nstab;
    int mode;
    bit lev1;
    cyc++;
    if (!rst) begin
      m_reset();
      return;
    end
    ev = m_ev; mode = m_mode; lev1 = m_stab[1];
    nstab = m_stab;
    // stable level follows a synced value that has disagreed for DEB straight cycles
    for (int b = 0; b < 3; b++) begin
      if (m_sy2[b] != m_stab[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DEB) begin
          nstab[b] = m_sy2[b];
          m_streak[b] = 0;
        end
      end else m_streak[b] = 0;
    end
    m_ev = m_rose;
    m_rose = nstab & ~m_stab;
    m_stab = nstab;
    m_sy2 = m_sy1;
    m_sy1 = ~raw;
    m_inc = 0; m_clr = 0;
    if (ev[2]) begin
      m_clr = 1; m_mode = 0; m_rep = 0;
    end else if (ev[0]) begin
      m_mode = (mode + 1) % 4; m_rep = 0;
    end else if (ev[1] && mode != 0) begin
      m_inc = 1;
`ifdef KEY_AUTOREPEAT_EN
      m_rep = 1; m_due = cyc + DLY;
`endif
    end else if (m_rep) begin
      if (!lev1) m_rep = 0;
      else if (cyc == m_due) begin
        m_inc = 1; m_due = cyc + PER;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(i_sw, rst_n);
    #1;
    chk("mode", int'(o_mode), m_mode);
    chk("inc", int'(o_inc), int'(m_inc));
    chk("clr", int'(o_clr), int'(m_clr));
    chk("sw_state", int'(o_sw_state), int'(m_stab));
  endtask

  task automatic apply(input logic [2:0] sw, input int hold,
                       output int incs, output int clrs);
    incs = 0; clrs = 0;
    @(negedge clk); i_sw = sw;
    for (int k = 0; k < hold; k++) begin
      tick(); incs += int'(o_inc); clrs += int'(o_clr);
    end
    @(negedge clk); i_sw = 3'b111;
    for (int k = 0; k < 12; k++) begin
      tick(); incs += int'(o_inc); clrs += int'(o_clr);
    end
  endtask

  // Press and hold mode key, measure edges until o_mode moves and count steps.
  task automatic mode_latency(input string tag, input int exp_mode);
    int got, changes;
    logic [1:0] prev;
    got = -1; changes = 0; prev = o_mode;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (o_mode != prev) begin
        changes++;
        if (got < 0) got = k;
        prev = o_mode;
      end
    end
    @(negedge clk); i_sw = 3'b111;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_mode != prev) begin changes++; prev = o_mode; end
    end
    chk({tag, "_latency"}, got, 2 + DEB + 2);
    chk({tag, "_steps"}, changes, 1);
    chk({tag, "_mode"}, int'(o_mode), exp_mode);
  endtask

  typedef struct {
    logic [2:0] sw;
    int hold;
    int mode;
    int incs;
    int clrs;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int incs, clrs;
    logic [2:0] sw;
    int r, dur;
    cyc = 0;
    m_reset();
    tbl[0]  = '{3'b110, 10, 2, 0, 0};
    tbl[1]  = '{3'b110, 10, 3, 0, 0};
    tbl[2]  = '{3'b110, 10, 0, 0, 0};
    tbl[3]  = '{3'b110, 3,  0, 0, 0};        // glitch shorter than debounce
    tbl[4]  = '{3'b101, 10, 0, 0, 0};        // increment ignored in RUN
    tbl[5]  = '{3'b110, 10, 1, 0, 0};
    tbl[6]  = '{3'b110, 10, 2, 0, 0};
    tbl[7]  = '{3'b101, 10, 2, 1, 0};
    tbl[8]  = '{3'b110, 10, 3, 0, 0};
    tbl[9]  = '{3'b000, 10, 0, 0, 1};        // all keys together: clear wins
    tbl[10] = '{3'b110, 10, 1, 0, 0};
    tbl[11] = '{3'b101, 50, 1, REP_INCS, 0}; // long hold in SEC

    #1;
    chk("reset_mode", int'(o_mode), 0);
    chk("reset_sw_state", int'(o_sw_state), 0);
    chk("reset_inc", int'(o_inc), 0);
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    @(negedge clk); i_sw = 3'b110;
    mode_latency("first_press", 1);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].sw, tbl[i].hold, incs, clrs);
      chk($sformatf("vec%0d_mode", i), int'(o_mode), tbl[i].mode);
      chk($sformatf("vec%0d_incs", i), incs, tbl[i].incs);
      chk($sformatf("vec%0d_clrs", i), clrs, tbl[i].clrs);
    end

    // Reset in the middle of a held mode press
    @(negedge clk); i_sw = 3'b110;
    for (int k = 0; k < 3; k++) tick();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("midrst_mode", int'(o_mode), 0);
    chk("midrst_sw_state", int'(o_sw_state), 0);
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk); rst_n = 1'b1;
    mode_latency("held_thru_reset", 1);

    // Random activity checked cycle by cycle against the model
    for (int s = 0; s < 160; s++) begin
      r = int'($urandom_range(0, 11));
      dur = int'($urandom_range(1, 14));
      case (r)
        0: sw = 3'b110;
        1: begin sw = 3'b101; dur = int'($urandom_range(1, 45)); end
        2: sw = 3'b011;
        3: sw = 3'($urandom);
        default: sw = 3'b111;
      endcase
      @(negedge clk); i_sw = sw;
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        m_reset();
        for (int k = 0; k < 2; k++) tick();
        @(negedge clk); rst_n = 1'b1;
      end
      for (int k = 0; k < dur; k++) tick();
    end
    @(negedge clk); i_sw = 3'b111;
    for (int k = 0; k < 20; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
